// File: rtl/multiword_add_seq.sv
// Multi-word adder/subtractor built around a single N-bit full_add slice.
// Operands of WORDS*N bits are processed LSB chunk first, one chunk per
// clock, with the carry held in a register between chunks.

// N-bit ripple slice: {o_carry, o_sum} = i_a + i_b + i_c
module full_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c};

endmodule

module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_start,
    input  logic                 input_sub,
    input  logic [N*WORDS-1:0]   input_a,
    input  logic [N*WORDS-1:0]   input_b,
    input  logic                 input_carry,
    output logic                 output_busy,
    output logic                 output_done,
    output logic [N*WORDS-1:0]   output_sum,
    output logic                 output_carry
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_a;        // operand A, shifted right one chunk per RUN cycle
    logic [W-1:0]   r_b;        // operand B (already inverted for subtract), shifted likewise
    logic           r_c;        // carry between chunks
    logic [IW-1:0]  r_idx;      // chunk currently being added
    logic [W-1:0]   r_acc;      // partial result accumulator
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_sum;
    logic           r_carry;

    logic [N-1:0]   w_slice_sum;
    logic           w_slice_cout;
    logic [W-1:0]   w_acc_nxt;

    // The one shared adder slice; current chunk always sits in the low bits
    full_add #(.N(N)) u_slice (
        .i_a     (r_a[N-1:0]),
        .i_b     (r_b[N-1:0]),
        .i_c     (r_c),
        .o_sum   (w_slice_sum),
        .o_carry (w_slice_cout)
    );

    // Accumulator with the slice result merged into chunk r_idx
    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IW'(k)) begin
                w_acc_nxt[k*N +: N] = w_slice_sum;
            end else begin
                w_acc_nxt[k*N +: N] = r_acc[k*N +: N];
            end
        end
    end

    // Next-state logic: IDLE -> RUN (WORDS cycles) -> DONE (one cycle) -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (input_start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, datapath and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_c     <= 1'b0;
            r_idx   <= {IW{1'b0}};
            r_acc   <= {W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= {W{1'b0}};
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (input_start) begin
                        // Subtract is a + ~b + 1, so carry-out reads as not-borrow
                        r_a   <= input_a;
                        r_b   <= input_sub ? ~input_b : input_b;
                        r_c   <= input_sub ? 1'b1 : input_carry;
                        r_idx <= {IW{1'b0}};
                        r_acc <= {W{1'b0}};
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> N;
                    r_b   <= r_b >> N;
                    r_c   <= w_slice_cout;
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + 1'b1;
                    // Final chunk: publish result so it is visible during DONE
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_acc_nxt;
                        r_carry <= w_slice_cout;
                    end else begin
                        r_sum   <= r_sum;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign output_busy  = r_busy;
    assign output_done  = r_done;
    assign output_sum   = r_sum;
    assign output_carry = r_carry;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=8, WORDS=4).
// A cycle-level model computes the result with plain wide arithmetic and the
// published latency; a compare process checks every cycle, and directed
// operations also check hand-computed literal results.
module tb_multiword_add_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         input_start = 1'b0;
    logic         input_sub = 1'b0;
    logic [W-1:0] input_a = '0;
    logic [W-1:0] input_b = '0;
    logic         input_carry = 1'b0;
    logic         output_busy;
    logic         output_done;
    logic [W-1:0] output_sum;
    logic         output_carry;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_start  (input_start),
        .input_sub    (input_sub),
        .input_a      (input_a),
        .input_b      (input_b),
        .input_carry  (input_carry),
        .output_busy  (output_busy),
        .output_done  (output_done),
        .output_sum   (output_sum),
        .output_carry (output_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: result = wide add of accepted operands, shown
    // WORDS edges after accept for one cycle, busy until WORDS+2 edges
    int           m_cnt = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_carry = 1'b0;
    logic [W:0]   m_res = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_carry = 1'b0;
        end else if (m_cnt == 0) begin
            m_done = 1'b0;
            if (input_start) begin
                if (input_sub)
                    m_res = {1'b0, input_a} + {1'b0, ~input_b} + 33'd1;
                else
                    m_res = {1'b0, input_a} + {1'b0, input_b} + {32'd0, input_carry};
                m_cnt  = 1;
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_cnt++;
            m_done = (m_cnt == WORDS + 1);
            if (m_done) begin
                m_sum   = m_res[W-1:0];
                m_carry = m_res[W];
            end
            if (m_cnt == WORDS + 2) begin
                m_cnt  = 0;
                m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  64'(output_busy),  64'(m_busy));
            chk("done",  64'(output_done),  64'(m_done));
            chk("sum",   64'(output_sum),   64'(m_sum));
            chk("carry", 64'(output_carry), 64'(m_carry));
        end
    end

    // One operation from an idle negedge; optional literal checks of result,
    // done latency (edges after accept) and busy length
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input logic lit,
                          input logic [W-1:0] es, input logic ec, input string nm);
        int k;
        int bcnt;
        logic got;
        logic [W-1:0] d_sum;
        logic         d_carry;
        input_a = a; input_b = b; input_sub = sub; input_carry = cin;
        input_start = 1'b1;
        @(negedge clk);
        input_start = 1'b0;
        input_a = ~a; input_b = a ^ b; input_carry = ~cin;
        bcnt = output_busy ? 1 : 0;
        k = 0;
        got = 1'b0;
        d_sum = '0;
        d_carry = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (output_busy) bcnt++;
            if (output_done) begin
                got = 1'b1;
                d_sum = output_sum;
                d_carry = output_carry;
                if (lit) begin
                    chk({nm, "_model_sum"}, 64'(m_sum), 64'(es));
                    chk({nm, "_model_carry"}, 64'(m_carry), 64'(ec));
                end
            end
        end
        if (!got) chk({nm, "_timeout"}, 64'(0), 64'(1));
        @(negedge clk);
        if (output_busy) bcnt++;
        if (lit) begin
            chk({nm, "_sum"}, 64'(d_sum), 64'(es));
            chk({nm, "_carry"}, 64'(d_carry), 64'(ec));
            chk({nm, "_latency"}, 64'(k), 64'(WORDS));
            chk({nm, "_busy_len"}, 64'(bcnt), 64'(WORDS + 1));
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (output_busy && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (output_busy) chk({nm, "_idle_timeout"}, 64'(output_busy), 64'(0));
    endtask

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(output_busy),  64'(0));
        chk("rst_done",  64'(output_done),  64'(0));
        chk("rst_sum",   64'(output_sum),   64'(0));
        chk("rst_carry", 64'(output_carry), 64'(0));
        chk_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);

        // Directed add/sub with hand-computed results
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000100, 1'b0, "add_ff_1");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, "add_ripple");
        run_op(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h00000001, 1'b0, "add_cin");
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b0, 1'b1, 32'h00000002, 1'b1, "sub_7_5");
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, "sub_5_7");
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 1'b1, 32'h00000002, 1'b1, "sub_cin_ign");
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b1, 32'hACF13569, 1'b0, "add_mixed");
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, "sub_equal");

        // Start held high with operands changing every cycle
        input_start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 24; i++) begin
            input_a = $urandom;
            input_b = $urandom;
            input_sub = i[0];
            input_carry = i[1];
            @(negedge clk);
            if (output_done) ndone++;
        end
        input_start = 1'b0;
        chk("held_start_dones", 64'(ndone), 64'(4));
        wait_idle("held_start");

        // Reset during the second RUN cycle
        input_a = 32'h12345678; input_b = 32'h00000001; input_sub = 1'b0; input_carry = 1'b0;
        input_start = 1'b1;
        @(negedge clk);
        input_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy",  64'(output_busy),  64'(0));
        chk("rst_mid_sum",   64'(output_sum),   64'(0));
        chk("rst_mid_carry", 64'(output_carry), 64'(0));
        chk("rst_mid_done",  64'(output_done),  64'(0));
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (output_done) ndone++;
        end
        chk("rst_mid_no_done", 64'(ndone), 64'(0));
        run_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b1, 32'h00000007, 1'b0, "add_3_4");

        // Random operations, model-checked every cycle
        for (int i = 0; i < 1000; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'b0, '0, 1'b0, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
